spi_flash_reader: RTL and testbench

SPI master read engine directly downstream of the OBI SPI ROM front-end. The ROM hands it a byte offset, and it runs one SPI-flash READ (0x03) transaction. It returns one 32-bit word assembled from 4 consecutive flash bytes. Single outstanding request, valid/ready handshake on both the request and response sides, SPI mode 0.

---
 rtl/spi_flash_reader.sv | 138 +++++++++++++
 tb/tb_spi_flash_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// SPI-flash READ engine: shifts out {CmdRead, address}, then shifts in 4 bytes
// and returns them as one little-endian 32-bit word. SPI mode 0, one request at a time.
module spi_flash_reader #(
   parameter int unsigned AddrWidth    = 24,
   parameter int unsigned ClkDiv       = 2,
   parameter logic [7:0]  CmdRead      = 8'h03,
   parameter int unsigned CsIdleCycles = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [AddrWidth-1:0] req_addr_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [31:0]          rsp_data_o,
   output logic                 busy_o,
   output logic                 spi_cs_n_o,
   output logic                 spi_sck_o,
   output logic                 spi_mosi_o,
   input  logic                 spi_miso_i
);
   localparam int unsigned ShiftW = 8 + AddrWidth;
   localparam int unsigned NBits  = ShiftW + 32;
   localparam int unsigned BitW   = $clog2(NBits);
   localparam int unsigned PhW    = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
   localparam int unsigned GapW   = (CsIdleCycles > 1) ? $clog2(CsIdleCycles) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, RESP, GAP} state_t;

   state_t            state, state_nxt;
   logic [ShiftW-1:0] sh;
   logic [31:0]       miso_sr;
   logic [BitW-1:0]   bit_cnt;
   logic [PhW-1:0]    phase_cnt;
   logic [GapW-1:0]   gap_cnt;
   logic              cs_n, sck, mosi, rsp_valid;
   logic [31:0]       rsp_data;
   logic              accept, phase_end, bit_last, gap_end, shift_done;

   assign req_ready_o = (state == IDLE) && !rst_i;
   assign busy_o      = (state != IDLE);
   assign spi_cs_n_o  = cs_n;
   assign spi_sck_o   = sck;
   assign spi_mosi_o  = mosi;
   assign rsp_valid_o = rsp_valid;
   assign rsp_data_o  = rsp_data;

   assign accept    = req_valid_i && req_ready_o;
   assign phase_end = (phase_cnt == PhW'(ClkDiv - 1));
   assign bit_last  = (bit_cnt == BitW'(NBits - 1));
   assign gap_end   = (gap_cnt == GapW'(CsIdleCycles - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      shift_done = 1'b0;
      case (state)
         IDLE:  if (accept) state_nxt = SHIFT;
         SHIFT: begin
            shift_done = !cs_n && sck && phase_end && bit_last;
            if (shift_done) state_nxt = RESP;
         end
         RESP:  if (rsp_ready_i) state_nxt = GAP;
         GAP:   if (gap_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // cs_n doubles as the "not started yet" flag: the first SHIFT cycle only
   // drops chip select and presents the command MSB.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sh        <= '0;
         miso_sr   <= '0;
         bit_cnt   <= '0;
         phase_cnt <= '0;
         gap_cnt   <= '0;
         cs_n      <= 1'b1;
         sck       <= 1'b0;
         mosi      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sh        <= {CmdRead, req_addr_i};
                  bit_cnt   <= '0;
                  phase_cnt <= '0;
               end
            end
            SHIFT: begin
               if (cs_n) begin
                  cs_n <= 1'b0;
                  mosi <= sh[ShiftW-1];
                  sh   <= sh << 1;
               end else if (!phase_end) begin
                  phase_cnt <= phase_cnt + PhW'(1);
               end else begin
                  phase_cnt <= '0;
                  if (!sck) begin
                     sck     <= 1'b1;
                     miso_sr <= {miso_sr[30:0], spi_miso_i};
                  end else begin
                     sck <= 1'b0;
                     if (bit_last) begin
                        cs_n      <= 1'b1;
                        mosi      <= 1'b0;
                        rsp_valid <= 1'b1;
                        // first byte received lands in the low byte
                        rsp_data  <= {miso_sr[7:0], miso_sr[15:8], miso_sr[23:16], miso_sr[31:24]};
                     end else begin
                        bit_cnt <= bit_cnt + BitW'(1);
                        mosi    <= sh[ShiftW-1];
                        sh      <= sh << 1;
                     end
                  end
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid <= 1'b0;
                  gap_cnt   <= '0;
               end
            end
            GAP: begin
               if (!gap_end) gap_cnt <= gap_cnt + GapW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: a behavioural SPI flash drives MISO, a scoreboard
// queue holds expected words, and directed steps cover timing, backpressure and reset.
module tb_spi_flash_reader;
   logic        clk, rst;
   logic        req_valid, req_ready, rsp_valid, rsp_ready, busy;
   logic [23:0] req_addr;
   logic [31:0] rsp_data;
   logic        cs_n, sck, mosi, miso;

   logic        b_req_valid, b_req_ready, b_rsp_valid, b_busy;
   logic [23:0] b_req_addr;
   logic [31:0] b_rsp_data;
   logic        b_cs_n, b_sck, b_mosi;

   int checks = 0, failures = 0;
   int ecount = 0;
   int t0, b_t0, rise_edge, acc_edge, ready_rise, base, fb;
   int rsp_count = 0, cs_low = 0, cs_falls = 0, hi_run = 0, last_hi = 0;
   int sck_rises = 0, fl_bits = 0, b_sck_rises = 0, b_viol = 0;
   logic [31:0] fl_cmd;
   logic vld_prev = 0, rdy_prev = 0, b_cs_prev = 1, b_sck_prev = 0;
   logic [31:0] exp_q[$];

   spi_flash_reader dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_addr_i(req_addr), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_data_o(rsp_data), .busy_o(busy), .spi_cs_n_o(cs_n), .spi_sck_o(sck),
      .spi_mosi_o(mosi), .spi_miso_i(miso));

   spi_flash_reader #(.ClkDiv(1)) dut_fast (
      .clk_i(clk), .rst_i(rst), .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
      .req_addr_i(b_req_addr), .rsp_valid_o(b_rsp_valid), .rsp_ready_i(1'b1),
      .rsp_data_o(b_rsp_data), .busy_o(b_busy), .spi_cs_n_o(b_cs_n), .spi_sck_o(b_sck),
      .spi_mosi_o(b_mosi), .spi_miso_i(1'b1));

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) ecount <= ecount + 1;

   function automatic logic [7:0] fbyte(input logic [23:0] a);
      case (a)
         24'h00, 24'h10: return 8'h20;
         24'h01, 24'h11: return 8'h4E;
         24'h02, 24'h12: return 8'h47;
         24'h03, 24'h13: return 8'h46;
         24'h04: return 8'h20;
         24'h05: return 8'h53;
         24'h06: return 8'h41;
         24'h07: return 8'h52;
         24'h08: return 8'h43;
         24'h09: return 8'h49;
         24'h0A: return 8'h53;
         24'h0B: return 8'h41;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Flash model: mode 0, MISO changes on SCK falling edges once cmd+addr are in.
   always @(negedge cs_n) begin
      fl_bits = 0; sck_rises = 0; fl_cmd = 0; cs_falls++;
   end
   always @(posedge sck) begin
      sck_rises++;
      if (fl_bits < 32) fl_cmd = {fl_cmd[30:0], mosi};
      fl_bits++;
   end
   always @(negedge sck) begin
      if (fl_bits >= 32) begin
         automatic int d = fl_bits - 32;
         automatic logic [7:0] b = fbyte(fl_cmd[23:0] + 24'(d / 8));
         miso = b[7 - (d % 8)];
      end
   end
   always @(posedge b_sck) b_sck_rises++;

   always @(negedge clk) begin
      if (!cs_n) cs_low++;
      if (cs_n) hi_run++;
      else begin
         if (hi_run > 0) last_hi = hi_run;
         hi_run = 0;
      end
      if (rsp_valid && !vld_prev) rise_edge = ecount;
      vld_prev = rsp_valid;
      if (req_ready && !rdy_prev) ready_rise = ecount;
      rdy_prev = req_ready;
      if (!b_cs_n && !b_cs_prev && (b_sck == b_sck_prev)) b_viol++;
      b_cs_prev = b_cs_n;
      b_sck_prev = b_sck;
      if (rsp_valid && rsp_ready) begin
         acc_edge = ecount + 1;
         rsp_count++;
         if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
         else check("rsp_data", rsp_data, exp_q.pop_front());
      end
   end

   task automatic wait_ready();
      automatic bit ok = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1; t0 = ecount + 1; break; end
      end
      check("ready_timeout", 32'(ok), 32'd1);
   endtask

   task automatic do_req(input logic [23:0] a);
      @(posedge clk); #1;
      req_valid = 1; req_addr = a;
      wait_ready();
      @(posedge clk); #1;
      req_valid = 0;
   endtask

   task automatic wait_rsp(input int n);
      automatic bit ok = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (rsp_count >= n) begin ok = 1; break; end
      end
      check("rsp_timeout", 32'(ok), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; req_valid = 0; req_addr = 0; rsp_ready = 1; miso = 0;
      b_req_valid = 0; b_req_addr = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cs_n", 32'(cs_n), 1);
      check("rst_sck", 32'(sck), 0);
      check("rst_mosi", 32'(mosi), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      @(posedge clk); #1; rst = 0;
      @(negedge clk);
      check("idle_req_ready", 32'(req_ready), 1);

      // 1: normal read
      cs_low = 0;
      exp_q.push_back(32'h4647_4E20);
      do_req(24'h000010);
      wait_rsp(1);
      check("t1_mosi_cmdaddr", fl_cmd, 32'h0300_0010);
      check("t1_sck_rises", 32'(sck_rises), 64);
      check("t1_cs_low", 32'(cs_low), 256);
      check("t1_rsp_latency", 32'(rise_edge - t0), 257);

      // 2: backpressure
      rsp_ready = 0;
      exp_q.push_back(32'h4647_4E20);
      do_req(24'h000000);
      begin
         automatic bit seen = 0, stable = 1;
         for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
         end
         check("t2_rsp_seen", 32'(seen), 1);
         for (int i = 0; i < 10; i++) begin
            if (!(rsp_valid && cs_n && !req_ready && rsp_data == 32'h4647_4E20)) stable = 0;
            @(negedge clk);
         end
         check("t2_stable_hold", 32'(stable), 1);
      end
      @(posedge clk); #1; rsp_ready = 1;
      repeat (6) @(negedge clk);
      check("t2_ready_delay", 32'(ready_rise - acc_edge), 2);
      check("t2_rsp_count", 32'(rsp_count), 2);

      // 3: back-to-back with req_valid held high
      @(posedge clk); #1;
      req_valid = 1; req_addr = 24'h000000;
      exp_q.push_back(32'h4647_4E20);
      exp_q.push_back(32'h5241_5320);
      wait_ready();
      @(posedge clk); #1; req_addr = 24'h000004;
      wait_ready();
      @(posedge clk); #1; req_valid = 0;
      wait_rsp(4);
      check("t3_cs_gap_ge3", 32'(last_hi >= 3), 1);

      // 4: request while busy is ignored
      base = rsp_count; fb = cs_falls;
      exp_q.push_back(32'h5241_5320);
      do_req(24'h000004);
      repeat (20) @(posedge clk);
      #1; req_valid = 1; req_addr = 24'h000100;
      @(negedge clk);
      check("t4_ready_while_busy", 32'(req_ready), 0);
      @(posedge clk); #1; req_valid = 0;
      wait_rsp(base + 1);
      repeat (400) @(negedge clk);
      check("t4_one_rsp", 32'(rsp_count), 32'(base + 1));
      check("t4_one_cs_fall", 32'(cs_falls), 32'(fb + 1));

      // 5: reset during data bits
      base = rsp_count;
      do_req(24'h000000);
      begin
         automatic bit ok = 0;
         for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            ok = (sck_rises >= 40);
         end
         check("t5_reach_data", 32'(ok), 1);
      end
      @(posedge clk); #1; rst = 1;
      @(posedge clk); #1; rst = 0;
      @(negedge clk);
      check("t5_cs_n", 32'(cs_n), 1);
      check("t5_sck", 32'(sck), 0);
      check("t5_busy", 32'(busy), 0);
      check("t5_rsp_valid", 32'(rsp_valid), 0);
      repeat (300) @(negedge clk);
      check("t5_no_rsp", 32'(rsp_count), 32'(base));
      exp_q.push_back(32'h4153_4943);
      do_req(24'h000008);
      wait_rsp(base + 1);

      // 6: ClkDiv=1 instance, MISO tied high
      b_sck_rises = 0; b_viol = 0;
      @(posedge clk); #1;
      b_req_valid = 1; b_req_addr = 24'hFFFFFC;
      begin
         automatic bit ok = 0;
         for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (b_req_ready) begin ok = 1; b_t0 = ecount + 1; end
         end
         check("t6_ready", 32'(ok), 1);
         @(posedge clk); #1; b_req_valid = 0;
         ok = 0;
         for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = b_rsp_valid;
         end
         check("t6_rsp_seen", 32'(ok), 1);
      end
      check("t6_rsp_latency", 32'(ecount - b_t0), 129);
      check("t6_rsp_data", b_rsp_data, 32'hFFFF_FFFF);
      check("t6_sck_toggle_viol", 32'(b_viol), 0);
      check("t6_sck_rises", 32'(b_sck_rises), 64);
      check("t6_mosi_idle", 32'(b_mosi), 0);
      check("t6_busy", 32'(b_busy), 1);

      check("final_queue_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
